pulse_to_level: RTL and testbench

Registered one-shot that turns a single-cycle strobe (the output of the team's edge detectors) back into a level of programmable length. It is the inverse of edge detection: a pulse in produces a clean high window out, followed by an optional lockout gap. It drives mole-lit windows, LED flashes and buzzer bursts from one-cycle game events.

---
 rtl/pulse_to_level.sv | 112 +++++++++++
 tb/tb_pulse_to_level.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pulse_to_level.sv
// pulse_to_level: registered one-shot that stretches a single-cycle strobe
// into a high window of hold_len cycles, followed by an optional lockout gap.
module pulse_to_level #(
  parameter int unsigned CW         = 8,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned RETRIGGER  = 1
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          pulse_in,
  input  logic [CW-1:0] hold_len,
  input  logic          abort,
  output logic          level_out,
  output logic          busy,
  output logic          done,
  output logic          dropped
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);
  localparam bit            RETRIG_EN = (RETRIGGER != 0);
  localparam logic [CW-1:0] GAP_LOAD  = HAS_GAP ? CW'(GAP_CYCLES - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d, dropped_d;
  logic          len_ok_c;

  assign len_ok_c = (hold_len != '0);

  // State, counter and registered outputs; outputs follow the next state
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_out <= (state_d == ACTIVE);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      dropped   <= dropped_d;
    end
  end

  // Next-state, counter update and event strobes; abort overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      dropped_d = pulse_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (pulse_in) begin
            if (len_ok_c) begin
              cnt_d   = hold_len - CW'(1);
              state_d = ACTIVE;
            end else begin
              dropped_d = 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (pulse_in && RETRIG_EN && len_ok_c) begin
            // restart the window even on its terminal cycle, so no done
            cnt_d = hold_len - CW'(1);
          end else begin
            dropped_d = pulse_in;
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
            end else begin
              done_d = 1'b1;
              if (HAS_GAP) begin
                cnt_d   = GAP_LOAD;
                state_d = GAP;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        GAP: begin
          dropped_d = pulse_in;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level: two instances share stimulus,
// u_a retriggers with no gap, u_b rejects retriggers and has a 2-cycle gap.
// Observed vector per instance is {level_out, busy, done, dropped}.
module tb_pulse_to_level;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       pulse_in;
  logic [7:0] hold_len;
  logic       abort;
  logic       lvl_a, busy_a, done_a, drop_a;
  logic       lvl_b, busy_b, done_b, drop_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pulse_to_level #(.CW(8), .GAP_CYCLES(0), .RETRIGGER(1)) u_a (
    .clk(clk), .n_reset(n_reset), .pulse_in(pulse_in), .hold_len(hold_len),
    .abort(abort), .level_out(lvl_a), .busy(busy_a), .done(done_a),
    .dropped(drop_a)
  );

  pulse_to_level #(.CW(8), .GAP_CYCLES(2), .RETRIGGER(0)) u_b (
    .clk(clk), .n_reset(n_reset), .pulse_in(pulse_in), .hold_len(hold_len),
    .abort(abort), .level_out(lvl_b), .busy(busy_b), .done(done_b),
    .dropped(drop_b)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b (level,busy,done,dropped)", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then compare both instances.
  task automatic cyc(input string tag, input int idx, input logic p, input logic [7:0] h,
                     input logic ab, input logic rn,
                     input logic [3:0] ea, input bit ca,
                     input logic [3:0] eb, input bit cb);
    pulse_in = p;
    hold_len = h;
    abort    = ab;
    n_reset  = rn;
    @(posedge clk);
    #1;
    if (ca) check($sformatf("%s_a_e%0d", tag, idx), {lvl_a, busy_a, done_a, drop_a}, ea);
    if (cb) check($sformatf("%s_b_e%0d", tag, idx), {lvl_b, busy_b, done_b, drop_b}, eb);
    pulse_in = 1'b0;
    abort    = 1'b0;
    n_reset  = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    cyc(tag, 0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1);
  endtask

  logic [3:0] exp_b3 [12];
  logic       pul_b3 [12];

  initial begin
    pulse_in = 1'b0;
    hold_len = 8'd0;
    abort    = 1'b0;
    n_reset  = 1'b0;

    // reset state
    do_reset("rst0");
    do_reset("rst1");

    // basic window, hold_len=5; u_b adds a 2-cycle gap after done
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ea, eb;
      ea = (i < 5) ? 4'b1100 : (i == 5) ? 4'b0010 : 4'b0000;
      eb = (i < 5) ? 4'b1100 : (i == 5) ? 4'b0110 : (i == 6) ? 4'b0100 : 4'b0000;
      cyc("basic", i, (i == 0), 8'd5, 1'b0, 1'b1, ea, 1'b1, eb, 1'b1);
    end

    // retrigger at edge 2 with a new length of 6
    do_reset("rst_rt");
    for (int i = 0; i < 10; i++) begin
      logic [3:0] ea;
      ea = (i < 8) ? 4'b1100 : (i == 8) ? 4'b0010 : 4'b0000;
      cyc("retrig", i, (i == 0 || i == 2), (i == 2) ? 8'd6 : 8'd4, 1'b0, 1'b1,
          ea, 1'b1, 4'b0000, 1'b0);
    end

    // retrigger on the terminal cycle: no done, window restarts
    do_reset("rst_term");
    cyc("term", 0, 1'b1, 8'd2, 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0000, 1'b0);
    cyc("term", 1, 1'b0, 8'd2, 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0000, 1'b0);
    cyc("term", 2, 1'b1, 8'd1, 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0000, 1'b0);
    cyc("term", 3, 1'b0, 8'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0);

    // gap lockout on u_b, hold_len=3, includes done+dropped coincidence
    exp_b3 = '{4'b1100, 4'b1101, 4'b1100, 4'b0111, 4'b0101, 4'b0001,
               4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100, 4'b0000};
    pul_b3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset("rst_gap");
    for (int i = 0; i < 12; i++) begin
      cyc("gap", i, pul_b3[i], 8'd3, 1'b0, 1'b1, 4'b0000, 1'b0, exp_b3[i], 1'b1);
    end

    // zero length in IDLE, then zero-length retrigger while ACTIVE
    do_reset("rst_zero");
    cyc("zero", 0, 1'b1, 8'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1);
    cyc("zero", 1, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1);
    cyc("zact", 0, 1'b1, 8'd2, 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0000, 1'b0);
    cyc("zact", 1, 1'b1, 8'd0, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0000, 1'b0);
    cyc("zact", 2, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0);
    cyc("zact", 3, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // abort together with a pulse at edge 4 of a 10-cycle window
    do_reset("rst_abort");
    for (int i = 0; i < 9; i++) begin
      logic [3:0] ea;
      ea = (i < 4) ? 4'b1100 : (i == 4) ? 4'b0001 : (i == 5) ? 4'b0000 :
           (i < 8) ? 4'b1100 : 4'b0010;
      cyc("abort", i, (i == 0 || i == 4 || i == 6), (i >= 6) ? 8'd2 : 8'd10,
          (i == 4), 1'b1, ea, 1'b1, 4'b0000, 1'b0);
    end

    // reset mid-window beats a coincident pulse; next pulse gives a fresh window
    do_reset("rst_mid");
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ea;
      ea = (i < 2) ? 4'b1100 : (i < 4) ? 4'b0000 : (i < 7) ? 4'b1100 : 4'b0010;
      cyc("midrst", i, (i == 0 || i == 2 || i == 4), (i == 4) ? 8'd3 : 8'd6,
          1'b0, (i != 2), ea, 1'b1, 4'b0000, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
